// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - CPU-side bus and handshake bundle for mem_access_unit
//
// Purpose: groups the control-unit strobes, the CPU data bus and the memory
// status/register outputs so that the control unit and the memory unit share
// one connection.
//
// Signals:
//   BusMuxOut [DATA_W]  CPU data bus (master -> slave)
//   MARin               load MAR from bus (master -> slave)
//   MDRin               load MDR from bus when MD_Read=0 (master -> slave)
//   MD_Read             MDR source select, 1 = memory path (master -> slave)
//   ReadRAM / WriteRAM  level requests, sampled while idle (master -> slave)
//   MAR_q [ADDR_W]      current MAR (slave -> master)
//   MDR_q [DATA_W]      current MDR (slave -> master)
//   mem_busy            transaction in progress (slave -> master)
//   mem_done            one-cycle completion pulse (slave -> master)
//   mem_err             out-of-range flag, present only with MEM_RANGE_ERR_EN
//
// Modports: master = control unit side, slave = mem_access_unit side.
interface mem_access_unit_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] BusMuxOut;
  logic              MARin;
  logic              MDRin;
  logic              MD_Read;
  logic              ReadRAM;
  logic              WriteRAM;
  logic [ADDR_W-1:0] MAR_q;
  logic [DATA_W-1:0] MDR_q;
  logic              mem_busy;
  logic              mem_done;
`ifdef MEM_RANGE_ERR_EN
  logic              mem_err;

  modport master (
    output BusMuxOut, MARin, MDRin, MD_Read, ReadRAM, WriteRAM,
    input  MAR_q, MDR_q, mem_busy, mem_done, mem_err
  );

  modport slave (
    input  BusMuxOut, MARin, MDRin, MD_Read, ReadRAM, WriteRAM,
    output MAR_q, MDR_q, mem_busy, mem_done, mem_err
  );
`else
  modport master (
    output BusMuxOut, MARin, MDRin, MD_Read, ReadRAM, WriteRAM,
    input  MAR_q, MDR_q, mem_busy, mem_done
  );

  modport slave (
    input  BusMuxOut, MARin, MDRin, MD_Read, ReadRAM, WriteRAM,
    output MAR_q, MDR_q, mem_busy, mem_done
  );
`endif
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MAR/MDR registers, word RAM and wait-state access FSM
//
// Purpose: performs the RAM access requested by the control unit. A request
// (ReadRAM/WriteRAM level) is sampled only while idle; the address and write
// data are snapshotted at that edge, WAIT_CYCLES wait states follow, then one
// ACCESS cycle and one DONE cycle. mem_busy/mem_done let the control unit stall.
//
// Ports:
//   clk    in   system clock, rising edge
//   Reset  in   synchronous, active-high reset (RAM contents are kept)
//   bus    slave modport of mem_access_unit_if:
//            in : BusMuxOut, MARin, MDRin, MD_Read, ReadRAM, WriteRAM
//            out: MAR_q, MDR_q, mem_busy, mem_done (+ mem_err, see below)
//
// Optional feature macro: MEM_RANGE_ERR_EN
//   defined   -> mem_err is driven high during DONE when the latched address
//                is >= MEM_DEPTH
//   undefined -> no mem_err port or logic; out-of-range handling is unchanged
module mem_access_unit #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int MEM_DEPTH   = 512,
  parameter int WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             Reset,
  mem_access_unit_if.slave bus
);

  localparam int              IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(MEM_DEPTH);
  localparam logic [2:0]      WAIT_INIT = 3'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        wait_cnt_q, wait_cnt_d;

  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;      // address snapshot for the transaction
  logic [DATA_W-1:0] wdata_q, wdata_d;    // write data snapshot for the transaction
  logic              is_write_q, is_write_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef MEM_RANGE_ERR_EN
  logic              err_q, err_d;
`endif

  logic [DATA_W-1:0] mem [0:MEM_DEPTH-1];
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] rd_word;
  logic              in_range;
  logic              req;

  assign req      = bus.ReadRAM | bus.WriteRAM;
  assign in_range = ({1'b0, addr_q} < DEPTH_L);
  assign mem_idx  = addr_q[IDX_W-1:0];
  // Read data is only consumed at the edge leaving ACCESS, where it is
  // registered into MDR, so the RAM behaves as a synchronous read.
  assign rd_word  = mem[mem_idx];

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (WAIT_CYCLES > 0) begin
            state_d    = S_WAIT;
            wait_cnt_d = WAIT_INIT;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == 3'd0) begin
          state_d = S_ACCESS;
        end else begin
          wait_cnt_d = wait_cnt_q - 3'd1;
        end
      end
      S_ACCESS: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM outputs: computed from the next state so the registered copies line
  // up exactly with the state they describe.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
`ifdef MEM_RANGE_ERR_EN
    // addr_q is stable from ACCESS into DONE, so it is the latched address here.
    err_d  = (state_d == S_DONE) && !in_range;
`endif
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef MEM_RANGE_ERR_EN
      err_q  <= 1'b0;
`endif
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
`ifdef MEM_RANGE_ERR_EN
      err_q  <= err_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // MAR / MDR / transaction snapshot
  // ---------------------------------------------------------------------------
  always_comb begin
    mar_d      = mar_q;
    mdr_d      = mdr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;

    if (state_q == S_IDLE) begin
      // Snapshot uses the current register values, so a MARin/MDRin in the
      // same cycle as the request only affects later transactions.
      if (req) begin
        addr_d     = mar_q;
        wdata_d    = mdr_q;
        is_write_d = bus.WriteRAM;
      end
      if (bus.MARin) begin
        mar_d = bus.BusMuxOut[ADDR_W-1:0];
      end
      if (bus.MDRin && !bus.MD_Read) begin
        mdr_d = bus.BusMuxOut;
      end
    end

    if ((state_q == S_ACCESS) && !is_write_q) begin
      mdr_d = in_range ? rd_word : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      mar_q      <= '0;
      mdr_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
    end else begin
      mar_q      <= mar_d;
      mdr_q      <= mdr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      is_write_q <= is_write_d;
    end
  end

  // ---------------------------------------------------------------------------
  // RAM write port: no reset on contents; Reset on the ACCESS edge aborts.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!Reset && (state_q == S_ACCESS) && is_write_q && in_range) begin
      mem[mem_idx] <= wdata_q;
    end
  end

  assign bus.MAR_q    = mar_q;
  assign bus.MDR_q    = mdr_q;
  assign bus.mem_busy = busy_q;
  assign bus.mem_done = done_q;
`ifdef MEM_RANGE_ERR_EN
  assign bus.mem_err  = err_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized bench for mem_access_unit against a behavioural model
`timescale 1ns/1ps
module tb_mem_access_unit;
  localparam int AW   = 9;
  localparam int DW   = 32;
  localparam int NDUT = 3;

  // dut0: WAIT_CYCLES=0, depth 512; dut1: WAIT_CYCLES=1, depth 256; dut2: WAIT_CYCLES=7, depth 512
  function automatic int wait_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 7);
  endfunction
  function automatic int depth_of(input int k);
    return (k == 1) ? 256 : 512;
  endfunction

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] bus_v;
  logic          marin, mdrin, mdread, rdram, wrram;

  logic [NDUT-1:0] busy_a, done_a;
  logic [AW-1:0]   mar_a [NDUT];
  logic [DW-1:0]   mdr_a [NDUT];
`ifdef MEM_RANGE_ERR_EN
  logic [NDUT-1:0] err_a;
`endif

  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(AW), .DATA_W(DW)) ifs [NDUT] ();

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int WT  = (g == 0) ? 0 : ((g == 1) ? 1 : 7);
    localparam int DEP = (g == 1) ? 256 : 512;
    assign ifs[g].BusMuxOut = bus_v;
    assign ifs[g].MARin     = marin;
    assign ifs[g].MDRin     = mdrin;
    assign ifs[g].MD_Read   = mdread;
    assign ifs[g].ReadRAM   = rdram;
    assign ifs[g].WriteRAM  = wrram;
    assign busy_a[g] = ifs[g].mem_busy;
    assign done_a[g] = ifs[g].mem_done;
    assign mar_a[g]  = ifs[g].MAR_q;
    assign mdr_a[g]  = ifs[g].MDR_q;
`ifdef MEM_RANGE_ERR_EN
    assign err_a[g]  = ifs[g].mem_err;
`endif
    mem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEP), .WAIT_CYCLES(WT)) u_dut (
      .clk   (clk),
      .Reset (rst),
      .bus   (ifs[g])
    );
  end

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int k, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Behavioural model: a transaction keeps the unit busy for WAIT_CYCLES+2
  // cycles; the memory effect lands on the edge that starts the last one.
  int            m_remain [NDUT];
  logic [AW-1:0] m_mar    [NDUT];
  logic [AW-1:0] m_addr   [NDUT];
  logic [DW-1:0] m_mdr    [NDUT];
  logic [DW-1:0] m_wdata  [NDUT];
  bit            m_wr     [NDUT];
  logic [DW-1:0] m_mem    [NDUT][512];

  always @(posedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      if (rst) begin
        m_remain[k] = 0;
        m_mar[k]    = '0;
        m_mdr[k]    = '0;
      end else if (m_remain[k] == 0) begin
        if (rdram || wrram) begin
          m_addr[k]   = m_mar[k];
          m_wdata[k]  = m_mdr[k];
          m_wr[k]     = wrram;
          m_remain[k] = wait_of(k) + 2;
        end
        if (marin) m_mar[k] = bus_v[AW-1:0];
        if (mdrin && !mdread) m_mdr[k] = bus_v;
      end else begin
        m_remain[k]--;
        if (m_remain[k] == 1) begin
          if (m_wr[k]) begin
            if (int'(m_addr[k]) < depth_of(k)) m_mem[k][m_addr[k]] = m_wdata[k];
          end else begin
            m_mdr[k] = (int'(m_addr[k]) < depth_of(k)) ? m_mem[k][m_addr[k]] : '0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NDUT; k++) begin
        chk("busy", k, DW'(busy_a[k]), DW'(m_remain[k] > 0));
        chk("done", k, DW'(done_a[k]), DW'(m_remain[k] == 1));
        chk("mar",  k, DW'(mar_a[k]),  DW'(m_mar[k]));
        chk("mdr",  k, mdr_a[k],       m_mdr[k]);
`ifdef MEM_RANGE_ERR_EN
        chk("err",  k, DW'(err_a[k]),
            DW'((m_remain[k] == 1) && (int'(m_addr[k]) >= depth_of(k))));
`endif
      end
    end
  end

  task automatic cyc(input logic r, input logic mi, input logic di, input logic dr,
                     input logic rr, input logic wr, input logic [DW-1:0] b);
    rst = r; marin = mi; mdrin = di; mdread = dr; rdram = rr; wrram = wr; bus_v = b;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((|busy_a) && t < 30) begin
      idle();
      t++;
    end
    chk("idle_wait", 0, DW'(t < 30), 1);
  endtask

  int nb [NDUT];
  int nd [NDUT];
  int fd [NDUT];
  bit ed [NDUT];

  // Issue one request and watch the following 12 cycles.
  task automatic req(input logic rr, input logic wr);
    for (int k = 0; k < NDUT; k++) begin
      nb[k] = 0; nd[k] = 0; fd[k] = -1; ed[k] = 1'b0;
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, rr, wr, '0);
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < NDUT; k++) begin
        if (busy_a[k]) nb[k]++;
        if (done_a[k]) begin
          nd[k]++;
          if (fd[k] < 0) fd[k] = i;
`ifdef MEM_RANGE_ERR_EN
          ed[k] = err_a[k];
`endif
        end
      end
      idle();
    end
  endtask

  task automatic ld_mar(input logic [DW-1:0] b);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, b);
  endtask
  task automatic ld_mdr(input logic [DW-1:0] b);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, b);
  endtask

  function automatic logic [AW-1:0] pick_addr();
    int r = $urandom_range(0, 23);
    return (r < 16) ? AW'(r) : AW'(9'h1F8 + r - 16);
  endfunction

  int exp_nb [NDUT] = '{2, 3, 9};
  int exp_fd [NDUT] = '{1, 2, 8};

  initial begin
    rst = 1'b1; marin = 1'b0; mdrin = 1'b0; mdread = 1'b0; rdram = 1'b0; wrram = 1'b0; bus_v = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
    for (int k = 0; k < NDUT; k++) begin
      chk("rst_busy", k, DW'(busy_a[k]), 0);
      chk("rst_done", k, DW'(done_a[k]), 0);
      chk("rst_mar",  k, DW'(mar_a[k]),  0);
      chk("rst_mdr",  k, mdr_a[k],       0);
    end
    idle();

    // Prime every address the random phase may touch.
    for (int i = 0; i < 24; i++) begin
      ld_mar((i < 16) ? DW'(i) : DW'(9'h1F8 + i - 16));
      ld_mdr($urandom);
      req(1'b0, 1'b1);
    end

    // Write then read 0xDEADBEEF at address 5.
    ld_mar(32'h0000_0005);
    ld_mdr(32'hDEAD_BEEF);
    req(1'b0, 1'b1);
    for (int k = 0; k < NDUT; k++) begin
      chk("wr_done_at", k, DW'(fd[k]), DW'(exp_fd[k]));
      chk("wr_busy_len", k, DW'(nb[k]), DW'(exp_nb[k]));
    end
    ld_mdr(32'h0);
    req(1'b1, 1'b0);
    for (int k = 0; k < NDUT; k++) begin
      chk("rd_busy_len", k, DW'(nb[k]), DW'(exp_nb[k]));
      chk("rd_done_at", k, DW'(fd[k]), DW'(exp_fd[k]));
      chk("rd_data", k, mdr_a[k], 32'hDEAD_BEEF);
      chk("model_rd_data", k, m_mdr[k], 32'hDEAD_BEEF);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1111_1111);
    for (int k = 0; k < NDUT; k++) chk("md_read_blocks", k, mdr_a[k], 32'hDEAD_BEEF);

    // Read and write together: the write wins, one done pulse.
    ld_mar(32'h10);
    ld_mdr(32'h1234);
    req(1'b1, 1'b1);
    for (int k = 0; k < NDUT; k++) begin
      chk("both_mdr", k, mdr_a[k], 32'h1234);
      chk("both_ndone", k, DW'(nd[k]), 1);
    end
    ld_mdr(32'h0);
    req(1'b1, 1'b0);
    for (int k = 0; k < NDUT; k++) chk("both_readback", k, mdr_a[k], 32'h1234);

    // Strobes during a transaction are ignored.
    ld_mar(32'h7);
    ld_mdr(32'h77);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h20);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
    wait_idle();
    idle();
    for (int k = 0; k < NDUT; k++) begin
      chk("busy_mar_hold", k, DW'(mar_a[k]), 32'h7);
      chk("busy_mdr_hold", k, mdr_a[k], 32'h77);
    end
    ld_mdr(32'h0);
    req(1'b1, 1'b0);
    for (int k = 0; k < NDUT; k++) chk("busy_wr_addr", k, mdr_a[k], 32'h77);

    // Reset on dut1's ACCESS edge aborts its write to address 3.
    ld_mar(32'h3);
    ld_mdr(32'hAAAA_AAAA);
    req(1'b0, 1'b1);
    ld_mdr(32'h5555_5555);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    idle();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("abort_busy", 1, DW'(busy_a[1]), 0);
    chk("abort_done", 1, DW'(done_a[1]), 0);
    chk("abort_mar",  1, DW'(mar_a[1]),  0);
    chk("abort_mdr",  1, mdr_a[1],       0);
    idle();
    ld_mar(32'h3);
    req(1'b1, 1'b0);
    chk("abort_mem", 0, mdr_a[0], 32'h5555_5555);
    chk("abort_mem", 1, mdr_a[1], 32'hAAAA_AAAA);
    chk("abort_mem", 2, mdr_a[2], 32'hAAAA_AAAA);

    // MAR keeps only the low ADDR_W bits.
    ld_mar(32'h5);
    ld_mar(32'h0000_0200);
    for (int k = 0; k < NDUT; k++) chk("mar_wrap", k, DW'(mar_a[k]), 0);

    // Out-of-range read on the 256-deep instance.
    ld_mar(32'h1FF);
    ld_mdr(32'hCAFE);
    req(1'b1, 1'b0);
    chk("oor_read", 1, mdr_a[1], 0);
    chk("oor_done_at", 1, DW'(fd[1]), 2);
`ifdef MEM_RANGE_ERR_EN
    chk("oor_err", 1, DW'(ed[1]), 1);
    chk("inrange_err", 0, DW'(ed[0]), 0);
`endif

    // Random traffic; the per-cycle compare against the model does the checking.
    for (int i = 0; i < 3000; i++) begin
      logic [DW-1:0] b;
      logic          mi;
      b  = $urandom;
      mi = ($urandom_range(0, 2) == 0);
      if (mi) b[AW-1:0] = pick_addr();
      cyc(($urandom_range(0, 99) == 0), mi, ($urandom_range(0, 2) == 0),
          $urandom_range(0, 1) == 1, ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 3) == 0), b);
    end
    idle();
    wait_idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
